// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: E/M and M/W pipeline registers, store
// formatting, load extension, and a ready/req handshake with a
// variable-latency data memory. The handshake gives up after MAX_WAIT
// WAIT cycles.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic [1:0]  StoreSrcE,
  input  logic [2:0]  LoadSrcE,
  input  logic [4:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        RegWriteM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic        MemBusyM,
  output logic        MisalignedM,
  output logic        BusErrorM,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;

  logic        r_memwrite_m;
  logic [1:0]  r_resultsrc_m;
  logic [1:0]  r_storesrc_m;
  logic [2:0]  r_loadsrc_m;
  logic [31:0] r_wdata_m;
  logic [31:0] r_pc4_m;

  logic [1:0]  r_resultsrc_w;
  logic [31:0] r_alu_w;
  logic [31:0] r_rdata_w;
  logic [31:0] r_pc4_w;

  logic        w_is_store, w_is_load, w_memop;
  logic        w_half, w_byte, w_word, w_mis;
  logic        w_req, w_abort;
  logic [3:0]  w_be_st;
  logic [31:0] w_wdata;
  logic [31:0] w_rshift;
  logic [15:0] w_half_lane;
  logic [7:0]  w_byte_lane;
  logic [31:0] w_load_data;

  // Access classification and alignment of the M slot
  always_comb begin
    w_is_store = r_memwrite_m;
    w_is_load  = !r_memwrite_m && (r_resultsrc_m == 2'b01);
    w_memop    = w_is_store || w_is_load;
    if (w_is_store) begin
      w_half = (r_storesrc_m == 2'b01);
      w_byte = (r_storesrc_m == 2'b10);
    end else begin
      w_half = (r_loadsrc_m == 3'b001) || (r_loadsrc_m == 3'b010);
      w_byte = (r_loadsrc_m == 3'b011) || (r_loadsrc_m == 3'b100);
    end
    w_word = !w_half && !w_byte;
    w_mis  = w_memop && ((w_word && (ALUResultM[1:0] != 2'b00)) ||
                         (w_half && ALUResultM[0]));
  end

  // Store data replication and byte enables
  always_comb begin
    w_wdata = r_wdata_m;
    w_be_st = 4'b1111;
    case (r_storesrc_m)
      2'b01: begin
        w_wdata = {2{r_wdata_m[15:0]}};
        w_be_st = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      2'b10: begin
        w_wdata = {4{r_wdata_m[7:0]}};
        w_be_st = 4'b0001 << ALUResultM[1:0];
      end
      default: ;
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    w_rshift    = dmem_rdata >> {ALUResultM[1:0], 3'b000};
    w_byte_lane = w_rshift[7:0];
    w_half_lane = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_loadsrc_m)
      3'b001:  w_load_data = {{16{w_half_lane[15]}}, w_half_lane};
      3'b010:  w_load_data = {16'h0000, w_half_lane};
      3'b011:  w_load_data = {{24{w_byte_lane[7]}}, w_byte_lane};
      3'b100:  w_load_data = {24'h000000, w_byte_lane};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // FSM state register and WAIT-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_IDLE) ? '0 : r_cnt + 8'd1;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req && !dmem_ready) w_next = S_WAIT;
      S_WAIT: if (dmem_ready || w_abort) w_next = S_IDLE;
    endcase
  end

  // FSM outputs: request, fault pulses and stall
  always_comb begin
    w_req       = 1'b0;
    w_abort     = 1'b0;
    MisalignedM = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req       = w_memop && !w_mis;
        MisalignedM = w_memop && w_mis;
      end
      S_WAIT: begin
        w_req   = 1'b1;
        w_abort = !dmem_ready && (r_cnt == CNT_LAST);
      end
    endcase
    BusErrorM  = w_abort;
    MemBusyM   = w_req && !dmem_ready && !w_abort;
    dmem_req   = w_req;
    dmem_we    = w_req && w_is_store;
    dmem_addr  = {ALUResultM[31:2], 2'b00};
    dmem_wdata = w_wdata;
    dmem_be    = w_is_store ? w_be_st : 4'b0000;
  end

  // E/M register: frozen while the access is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM     <= 1'b0;
      r_memwrite_m  <= 1'b0;
      r_resultsrc_m <= '0;
      r_storesrc_m  <= '0;
      r_loadsrc_m   <= '0;
      RdM           <= '0;
      ALUResultM    <= '0;
      r_wdata_m     <= '0;
      r_pc4_m       <= '0;
    end else if (!MemBusyM) begin
      RegWriteM     <= RegWriteE;
      r_memwrite_m  <= MemWriteE;
      r_resultsrc_m <= ResultSrcE;
      r_storesrc_m  <= StoreSrcE;
      r_loadsrc_m   <= LoadSrcE;
      RdM           <= RdE;
      ALUResultM    <= ALUResultE;
      r_wdata_m     <= WriteDataE;
      r_pc4_m       <= PCPlus4E;
    end
  end

  // M/W register: bubble while stalled or on abort; misaligned slots lose their write
  always_ff @(posedge clk) begin
    if (reset || MemBusyM || w_abort) begin
      RegWriteW     <= 1'b0;
      RdW           <= '0;
      r_resultsrc_w <= '0;
      r_alu_w       <= '0;
      r_rdata_w     <= '0;
      r_pc4_w       <= '0;
    end else begin
      RegWriteW     <= RegWriteM && !MisalignedM;
      RdW           <= RdM;
      r_resultsrc_w <= r_resultsrc_m;
      r_alu_w       <= ALUResultM;
      r_rdata_w     <= w_load_data;
      r_pc4_w       <= r_pc4_m;
    end
  end

  // Write-back result select
  always_comb begin
    case (r_resultsrc_w)
      2'b00:   ResultW = r_alu_w;
      2'b01:   ResultW = r_rdata_w;
      2'b10:   ResultW = r_pc4_w;
      default: ResultW = '0;
    endcase
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage RV32I pipeline: holds the E/M and M/W pipeline registers and runs the data-memory access between them. It formats stores and extends loads for byte, halfword and word accesses, and runs a ready/req handshake with a variable-latency data memory. While an access is outstanding it stalls the front of the pipe. It drives both forwarding sources back to the execute stage: ALUResultM and ResultW.

## Interface
- MAX_WAIT, 15: maximum cycles spent in WAIT before the access is abandoned; legal range 1..255.

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- RegWriteE, MemWriteE  in  1  execute-stage controls
- ResultSrcE  in  2  00 ALU, 01 load data, 10 PC+4, 11 zero
- StoreSrcE  in  2  00 sw, 01 sh, 10 sb; 11 treated as sw
- LoadSrcE  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw
- RdE  in  5  destination register
- ALUResultE, WriteDataE, PCPlus4E  in  32  execute-stage results
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address: {ALUResultM[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables; 0000 on loads
- dmem_ready  in  1  access completes in this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready=1
- RegWriteM, RdM  out  1/5  M-slot values, to the hazard unit
- ALUResultM  out  32  M-slot ALU result, for forwarding
- MemBusyM  out  1  stall request: freeze fetch, decode, execute and the E/M register
- MisalignedM, BusErrorM  out  1  one-cycle fault pulses
- RegWriteW, RdW  out  1/5  write-back controls
- ResultW  out  32  selected write-back value

## Operation
- E/M register: loads all E inputs each cycle when MemBusyM=0; holds its contents when MemBusyM=1.
- An M slot is a memory op when MemWriteM=1 or ResultSrcM=01.
- Misaligned access:
  - sw/lw with addr[1:0]≠00, or sh/lh/lhu with addr[0]=1.
  - No request is issued; MisalignedM=1 for one cycle.
  - The slot passes to W with RegWrite forced to 0.
- Store formatting:
  - sw: be=1111, wdata as given.
  - sh: wdata={2{wd[15:0]}}, be=0011<<{addr[1],0}.
  - sb: wdata={4{wd[7:0]}}, be=0001<<addr[1:0].
- Load extraction uses addr[1:0]: byte lane addr[1:0], half lane addr[1]. lh/lb sign-extend; lhu/lbu zero-extend.
- FSM states IDLE and WAIT.
  - IDLE with an aligned memory op: dmem_req=1. If dmem_ready=1, the access completes, the slot advances, and the state stays IDLE. Otherwise go to WAIT and clear the counter.
  - WAIT: dmem_req=1 with address, data and enables held stable. The counter increments each cycle.
    - On dmem_ready=1: complete, then go to IDLE.
    - When the counter reaches MAX_WAIT with no ready: drop the request, pulse BusErrorM, retire the slot as a bubble, then go to IDLE.
- MemBusyM=1 whenever a memory op is in M and this cycle neither completes nor aborts it.
- M/W register:
  - When MemBusyM=1 it captures a bubble (RegWriteW=0).
  - Otherwise it captures the M slot, with formatted load data latched as ReadDataW.
- ResultW mux: ResultSrcW 00 selects ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 zero.
- A dmem_ready seen while dmem_req=0 is ignored.

## Timing
- All registers are clocked on rising clk.
- dmem_* outputs, MemBusyM and the fault pulses are combinational from M state, the FSM and dmem_ready.
- Latency:
  - Zero-wait access: E to W in 2 cycles, with no stall.
  - n-wait access: MemBusyM is high for n cycles.
- Reset values:
  - All E/M and M/W fields are 0, so RegWriteM, RegWriteW, MemWriteM, RdM and RdW are 0 and ResultW=ALUResultW=0.
  - FSM in IDLE, counter 0, dmem_req=0, MemBusyM=0, fault pulses 0.
- Reset asserted in WAIT: dmem_req drops in the following cycle and the access is abandoned without writeback. The memory must tolerate an abandoned request.
- A fault cycle never asserts MemBusyM. The next instruction enters M in the following cycle.

## Test plan
- Zero-wait load: sw x5=0xDEADBEEF to 0x100, then lb from 0x103 with dmem_ready tied to 1.
  - Store issues be=1111.
  - Load yields ResultW=0xFFFFFFDE two cycles after E.
  - MemBusyM stays 0.
- Store formatting: sh 0x1234 to 0x102 → be=1100, wdata=0x12341234. sb 0xA5 to 0x101 → be=0010, wdata=0xA5A5A5A5.
- Wait states: lhu from 0x102 with ready delayed 3 cycles and rdata=0x8001_0000.
  - MemBusyM is high for exactly 3 cycles with dmem_addr and dmem_be stable.
  - ResultW=0x00008001.
  - E/M contents are held unchanged throughout.
- Misaligned: lw from 0x101.
  - dmem_req never rises; MisalignedM pulses for 1 cycle.
  - RegWriteW=0 for that slot; the next instruction proceeds.
- Timeout: MAX_WAIT=4 with dmem_ready held 0.
  - BusErrorM pulses in the 5th request cycle (IDLE cycle plus 4 WAIT cycles).
  - dmem_req drops afterwards and no register write occurs.
- Reset in WAIT: assert reset on the 2nd wait cycle.
  - The next cycle shows dmem_req=0, IDLE, and RegWriteW=0.
  - A late dmem_ready is ignored.
